pwr_sequencer: RTL

//  Power-rail sequencer for the pwr_ctrl design. Downstream consumer of the prescaler's slow divided clock (q1, 50 Hz).

---
 rtl/pwr_sequencer_if.sv | 21 ++
 rtl/pwr_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwr_sequencer_if.sv
// Signal bundle between the front panel / rail supplies and pwr_sequencer.
// master drives the raw inputs, slave is the sequencer itself.
interface pwr_sequencer_if;
    logic       tick;
    logic       btn;
    logic [1:0] pg;
    logic [1:0] en_rail;
    logic       pwr_on;
    logic       fault;
    logic       led;

    modport master (
        output tick, btn, pg,
        input  en_rail, pwr_on, fault, led
    );

    modport slave (
        input  tick, btn, pg,
        output en_rail, pwr_on, fault, led
    );
endinterface

// File: rtl/pwr_sequencer.sv
// Two-rail power sequencer: debounced button, ordered rail bring-up and
// reverse shutdown, fault latch. Optional blink LED via PWR_SEQ_BLINK_EN.
module pwr_sequencer #(
    parameter int DEB_TICKS  = 4,
    parameter int STEP_TICKS = 10,
    parameter int PG_TIMEOUT = 50,
    parameter int CW         = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    pwr_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_UP1   = 3'd1,
        S_UP2   = 3'd2,
        S_ON    = 3'd3,
        S_DN    = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [CW-1:0] L_DEB  = CW'(DEB_TICKS);
    localparam logic [CW-1:0] L_STEP = CW'(STEP_TICKS);
    localparam logic [CW-1:0] L_TO   = CW'(PG_TIMEOUT);
    localparam logic [CW-1:0] L_MAX  = '1;

    logic [1:0]    r_tick_s;
    logic          r_tick_d;
    logic [1:0]    r_btn_s;
    logic [1:0]    r_pg_m;
    logic [1:0]    r_pg_s;
    logic [CW-1:0] r_deb_cnt;
    logic          r_btn_db;
    logic          r_btn_db_d;
    logic [CW-1:0] r_tmr;
    state_t        r_state;
    logic [1:0]    r_en;
    logic          r_pwr_on;
    logic          r_fault;

    logic          w_tick_p;
    logic          w_btn;
    logic          w_press;
    logic          w_chg;
    logic [CW-1:0] w_deb_inc;
    state_t        w_next;
    logic [1:0]    w_en;
    logic          w_pwr_on;
    logic          w_fault;

    assign w_tick_p  = r_tick_s[1] & ~r_tick_d;
    assign w_btn     = r_btn_s[1];
    assign w_press   = r_btn_db & ~r_btn_db_d;
    assign w_deb_inc = r_deb_cnt + CW'(1);
    assign w_chg     = (w_next != r_state);

    // Synchronise the asynchronous inputs and edge-detect the tick
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_s <= '0;
            r_tick_d <= 1'b0;
            r_btn_s  <= '0;
            r_pg_m   <= '0;
            r_pg_s   <= '0;
        end else begin
            r_tick_s <= {r_tick_s[0], bus.tick};
            r_tick_d <= r_tick_s[1];
            r_btn_s  <= {r_btn_s[0], bus.btn};
            r_pg_m   <= bus.pg;
            r_pg_s   <= r_pg_m;
        end
    end

    // Debounce: level must disagree for DEB_TICKS ticks in a row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_cnt  <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (w_btn == r_btn_db) begin
                r_deb_cnt <= '0;
            end else if (w_tick_p) begin
                if (w_deb_inc == L_DEB) begin
                    r_btn_db  <= w_btn;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= w_deb_inc;
                end
            end
        end
    end

    // Per-state tick timer, saturating, cleared on every transition
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmr <= '0;
        end else if (w_chg) begin
            r_tmr <= '0;
        end else if (w_tick_p && r_tmr != L_MAX) begin
            r_tmr <= r_tmr + CW'(1);
        end
    end

    // State register with outputs registered on state entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_OFF;
            r_en     <= '0;
            r_pwr_on <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_en     <= w_en;
            r_pwr_on <= w_pwr_on;
            r_fault  <= w_fault;
        end
    end

    // Next state (fault > press > timed step) and entry outputs
    always_comb begin
        w_next   = r_state;
        w_en     = 2'b00;
        w_pwr_on = 1'b0;
        w_fault  = 1'b0;
        case (r_state)
            S_OFF: begin
                if (w_press)
                    w_next = S_UP1;
            end
            S_UP1: begin
                if (r_tmr == L_TO && !r_pg_s[0])
                    w_next = S_FAULT;
                else if (w_press)
                    w_next = S_DN;
                else if (r_pg_s[0] && r_tmr >= L_STEP)
                    w_next = S_UP2;
            end
            S_UP2: begin
                if (!r_pg_s[0] || (r_tmr == L_TO && !r_pg_s[1]))
                    w_next = S_FAULT;
                else if (w_press)
                    w_next = S_DN;
                else if (r_pg_s[1] && r_tmr >= L_STEP)
                    w_next = S_ON;
            end
            S_ON: begin
                if (r_pg_s != 2'b11)
                    w_next = S_FAULT;
                else if (w_press)
                    w_next = S_DN;
            end
            S_DN: begin
                if (r_tmr >= L_STEP)
                    w_next = S_OFF;
            end
            S_FAULT: begin
                if (w_press)
                    w_next = S_OFF;
            end
            default: w_next = S_OFF;
        endcase
        case (w_next)
            S_UP1, S_DN: w_en = 2'b01;
            S_UP2:       w_en = 2'b11;
            S_ON: begin
                w_en     = 2'b11;
                w_pwr_on = 1'b1;
            end
            S_FAULT:     w_fault = 1'b1;
            default:     w_en = 2'b00;
        endcase
    end

    assign bus.en_rail = r_en;
    assign bus.pwr_on  = r_pwr_on;
    assign bus.fault   = r_fault;

`ifdef PWR_SEQ_BLINK_EN
    logic       r_led;
    logic [2:0] r_blk;
    logic       w_led;

    // LED level for the state being entered or held
    always_comb begin
        w_led = r_led;
        case (w_next)
            S_UP1, S_UP2, S_DN: w_led = r_led ^ w_tick_p;
            S_ON:               w_led = 1'b1;
            S_FAULT: begin
                if (w_chg)
                    w_led = 1'b0;
                else if (w_tick_p && r_blk == 3'd7)
                    w_led = ~r_led;
            end
            default:            w_led = 1'b0;
        endcase
    end

    // LED register and the slow FAULT blink divider
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led <= 1'b0;
            r_blk <= '0;
        end else begin
            r_led <= w_led;
            if (w_chg)
                r_blk <= '0;
            else if (w_tick_p)
                r_blk <= r_blk + 3'd1;
        end
    end

    assign bus.led = r_led;
`else
    assign bus.led = r_pwr_on;
`endif
endmodule
